accum_resp: RTL
===============

// Module: accum_resp
// PURPOSE
//  Responder end of the val_op/op_ack/op_commit request protocol. Accepts signed-op
//  requests (add/sub) from an initiator (bench or upstream controller), applies them
//  to a saturating accumulator over a fixed multi-cycle execute, then signals commit.
//  Optional scan chain over the accumulator for state observe/load.
// PARAMETERS
//  W         8  data/accumulator width
//  EXEC_CYC  2  execute latency in cycles, >=1
// PORTS
//  clk        in   1  clock, all logic on posedge
//  reset      in   1  synchronous, active-low reset
//  data_in    in   W  request operand, sampled with val_op
//  a_s        in   1  1=add, 0=sub, sampled with val_op
//  val_op     in   1  request valid, level, held by initiator until op_ack
//  op_ack     out  1  request accepted, level, held until val_op drops
//  op_commit  out  1  one-cycle pulse: result valid on data_out/ovf
//  data_out   out  W  committed accumulator value
//  ovf        out  1  last committed op saturated
//  sen        in   1  scan enable
//  scan_ce    in   1  scan clock-enable (shift when sen&scan_ce)
//  sin        in   1  scan serial in
//  sout       out  1  scan serial out
// BEHAVIOUR
//  - reset==0 at posedge: state IDLE, acc=0, data_out=0, ovf=0, op_ack=0, op_commit=0,
//    exec counter=0, sout=0 (via acc=0). Reset mid-operation aborts it: no ack/commit follows.
//  - FSM IDLE->ACK->EXEC->COMMIT->IDLE, all outputs registered.
//  - IDLE: val_op=1 & sen=0 at edge -> latch opnd=data_in, op=a_s; op_ack=1; ->ACK.
//  - ACK: op_ack stays 1 while val_op=1 (any duration). val_op=0 at edge -> op_ack=0,
//    cnt=EXEC_CYC-1, ->EXEC. data_in/a_s changes after latch are ignored.
//  - EXEC: cnt decrements each edge; at edge with cnt==0: acc, data_out <= result,
//    ovf <= sat flag, op_commit=1, ->COMMIT. Commit is high EXEC_CYC edges after the
//    edge that sampled val_op=0.
//  - COMMIT: op_commit=0 at next edge, ->IDLE. Requests accepted only in IDLE; val_op
//    high during EXEC/COMMIT is taken on the first IDLE edge.
//  - Arithmetic, unsigned W bits: add: acc+opnd, clamp to 2^W-1, ovf=1 if carry out;
//    sub: acc-opnd, clamp to 0, ovf=1 if borrow. ovf otherwise 0; updated every commit.
//  - data_out changes only at commit (and reset).
// CONFIGURATION
//  SCAN_CHAIN_EN defined: in IDLE with sen=1: scan_ce=1 -> acc <= {sin, acc[W-1:1]},
//  sout=acc[0] (LSB first out, sin enters MSB); scan_ce=0 -> acc holds. val_op not
//  accepted while sen=1. sen ignored outside IDLE. data_out/ovf not touched by scan.
//  SCAN_CHAIN_EN undefined: sen/scan_ce/sin ignored, sout tied 0; ports remain present.
// STRUCTURE
//  - Shared header accum_resp_defs.vh: state encodings (IDLE/ACK/EXEC/COMMIT, 2 bits),
//    OP_ADD=1'b1, OP_SUB=1'b0.
//  - Sub-module sat_addsub (combinational, param W): a, b, op -> y, sat.
//  - Top: FSM, exec counter ($clog2(EXEC_CYC)+1 bits), operand latch, acc/scan register.
// TESTING (W=8, EXEC_CYC=2)
//  - reset=0 for 5 cycles -> data_out=0x00, ovf=0, op_ack=0, op_commit=0, sout=0.
//  - add 0x05 then sub 0x03 from reset -> commits data_out=0x05 then 0x02, ovf=0,
//    op_commit exactly 1 cycle each, 2 edges after val_op drop.
//  - acc=0xF0, add 0x20 -> 0xFF ovf=1; sub 0x10 -> 0xEF ovf=0; from 0x02 sub 0x03 -> 0x00 ovf=1.
//  - val_op held 10 cycles -> op_ack high throughout, no commit until val_op falls.
//  - reset=0 asserted during EXEC -> no op_commit, data_out=0x00, next request works normally.
//  - SCAN_CHAIN_EN, acc=0xA5 in IDLE, sen=scan_ce=1, sin=0x3C LSB-first for 8 cycles ->
//    sout 1,0,1,0,0,1,0,1; then add 0x01 -> data_out=0x3D. Undefined: sout stays 0.

Source files
------------

// File: rtl/accum_resp_pkg.sv
// Shared definitions for the accum_resp responder: FSM state encoding and op codes.
package accum_resp_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACK    = 2'd1,
    EXEC   = 2'd2,
    COMMIT = 2'd3
  } state_t;

  localparam logic OP_ADD = 1'b1;
  localparam logic OP_SUB = 1'b0;

endpackage

// File: rtl/accum_resp_if.sv
// Request/commit bus between an initiator (master) and the accum_resp responder (slave).
interface accum_resp_if #(
  parameter int W = 8
);
  // val_op is a level held by the initiator until op_ack rises; op_ack then stays
  // high until val_op drops; data_in/a_s are captured once, on acceptance.
  // op_commit is a single-cycle pulse qualifying data_out/ovf.
  logic [W-1:0] data_in;
  logic         a_s;
  logic         val_op;
  logic         op_ack;
  logic         op_commit;
  logic [W-1:0] data_out;
  logic         ovf;

  modport master (
    output data_in, a_s, val_op,
    input  op_ack, op_commit, data_out, ovf
  );

  modport slave (
    input  data_in, a_s, val_op,
    output op_ack, op_commit, data_out, ovf
  );
endinterface

// File: rtl/accum_resp_sat_addsub.sv
// Unsigned W-bit add/subtract that clamps to 2^W-1 on carry and to 0 on borrow.
module accum_resp_sat_addsub
  import accum_resp_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         op,
  output logic [W-1:0] y,
  output logic         sat
);

  logic [W:0] ext;

  always_comb begin
    ext = '0;
    y   = '0;
    sat = 1'b0;
    case (op)
      OP_ADD: begin
        ext = {1'b0, a} + {1'b0, b};
        sat = ext[W];
        y   = sat ? '1 : ext[W-1:0];
      end
      OP_SUB: begin
        ext = {1'b0, a} - {1'b0, b};
        sat = ext[W];
        y   = sat ? '0 : ext[W-1:0];
      end
    endcase
  end

endmodule

// File: rtl/accum_resp.sv
// Saturating accumulator responder: IDLE->ACK->EXEC->COMMIT handshake FSM.
// Define SCAN_CHAIN_EN to enable the serial scan chain over the accumulator.
module accum_resp
  import accum_resp_pkg::*;
#(
  parameter int W        = 8,
  parameter int EXEC_CYC = 2
) (
  input  logic          clk,
  input  logic          reset,
  accum_resp_if.slave   bus,
  input  logic          sen,
  input  logic          scan_ce,
  input  logic          sin,
  output logic          sout,
  output state_t        fsm_state
);

  localparam int CW = $clog2(EXEC_CYC) + 1;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [W-1:0]   acc;
  logic [W-1:0]   opnd;
  logic           op;
  logic [W-1:0]   result;
  logic           sat;
  logic [W-1:0]   data_q;
  logic           ovf_q;
  logic           ack_q;
  logic           commit_q;
  logic           scan_block;
  logic           scan_shift;
  logic           scan_bit;

`ifdef SCAN_CHAIN_EN
  assign scan_block = sen;
  assign scan_shift = sen & scan_ce;
  assign scan_bit   = sin;
  assign sout       = acc[0];
`else
  logic unused_scan;
  assign unused_scan = ^{sen, scan_ce, sin};
  assign scan_block  = 1'b0;
  assign scan_shift  = 1'b0;
  assign scan_bit    = 1'b0;
  assign sout        = 1'b0;
`endif

  accum_resp_sat_addsub #(.W(W)) u_alu (
    .a   (acc),
    .b   (opnd),
    .op  (op),
    .y   (result),
    .sat (sat)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      opnd     <= '0;
      op       <= OP_SUB;
      data_q   <= '0;
      ovf_q    <= 1'b0;
      ack_q    <= 1'b0;
      commit_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.val_op && !scan_block) begin
            opnd  <= bus.data_in;
            op    <= bus.a_s;
            ack_q <= 1'b1;
            state <= ACK;
          end else if (scan_shift) begin
            acc <= {scan_bit, acc[W-1:1]};
          end
        end
        ACK: begin
          if (!bus.val_op) begin
            ack_q <= 1'b0;
            cnt   <= CW'(EXEC_CYC - 1);
            state <= EXEC;
          end
        end
        EXEC: begin
          // cnt counts down the remaining edges; the commit lands on the edge that sees 0
          if (cnt == '0) begin
            acc      <= result;
            data_q   <= result;
            ovf_q    <= sat;
            commit_q <= 1'b1;
            state    <= COMMIT;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        COMMIT: begin
          commit_q <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.op_ack    = ack_q;
  assign bus.op_commit = commit_q;
  assign bus.data_out  = data_q;
  assign bus.ovf       = ovf_q;
  assign fsm_state     = state;

endmodule
